calc_cu: RTL and testbench
==========================

# calc_cu

Control unit for the 4-bit calculator datapath `DP`. It accepts a start request with a 3-bit function code, then sequences the datapath's enables, operation selects and output muxing through load, compute, iterate and display phases. It waits on the datapath's `Done_Calc_dp` / `Done_DIV_dp` flags and reports completion to the top level. It sits between the board-level inputs (buttons/switches) and `DP`, with one control word per state.

## Interface
- `MAX_WAIT`, 16: cycles allowed in an iterate state before declaring a timeout (≥2).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Go` in 1: start request, sampled only in IDLE.
- `F` in 3: function code: 000 add, 001 sub, 010 and, 011 xor, 100 div, 101 mul, 110 show A, 111 show B.
- `Done_Calc` in 1: ALU completion flag from `DP`.
- `Done_DIV` in 1: divider completion flag from `DP`.
- `EN_F`, `EN_X`, `EN_Y` out 1 each: function/operand register loads.
- `Go_Calc` out 1: ALU run.
- `Op_Calc` out 2: ALU op, equal to the latched `F[1:0]`.
- `Go_DIV` out 1: divider run.
- `Sel_H` out 1: high-result source select.
- `Sel_L` out 2: low-result source select.
- `En_Out_H`, `En_Out_L` out 1 each: result register loads.
- `Sel_out` out 2: display mux select.
- `Done` out 1: operation complete. High for exactly one cycle.
- `Err` out 1: timeout. High for exactly one cycle.
- `Busy` out 1: high in every state except IDLE.

## Operation
- Moore FSM. All outputs decode from the state register only, except `Op_Calc`, which comes from the internal `f_q` register.
- `f_q` (3 b) is loaded with `F` on the IDLE→S1 transition and holds until the next start.
- Control word order is {EN_F, EN_X, EN_Y, Go_Calc, Op_Calc, Go_DIV, Sel_H, Sel_L, En_Out_H, En_Out_L, Sel_out}. Signals not listed for a state are 0.
- **IDLE**: all outputs 0. If `Go`, go to S1.
- **S1**: EN_F=EN_X=EN_Y=1. Go to S2.
- **S2**: EN_F=1. Branch on `f_q`:
  - 0xx → CALC_START
  - 100 → DIV_START
  - 101 → MUL0
  - 110 → SHOW_A
  - 111 → SHOW_B
- **CALC_START**: Go_Calc=1. If `Done_Calc`, go to CALC_END; else go to CALC_ITER.
- **CALC_ITER**: Go_Calc=1, Sel_L=01, En_Out_L=1. Stay until `Done_Calc`, then go to CALC_END.
- **CALC_END**: Sel_L=01, En_Out_L=1. Go to DISP.
- **DIV_START**: Go_DIV=1. If `Done_DIV`, go to DIV_END; else go to DIV_ITER.
- **DIV_ITER**: Go_DIV=1, Sel_L=11, En_Out_H=En_Out_L=1. Stay until `Done_DIV`, then go to DIV_END.
- **DIV_END**: Sel_L=11, En_Out_H=En_Out_L=1. Go to DISP.
- **MUL0**: Sel_H=1, Sel_L=10. Go to MUL1.
- **MUL1**: Sel_H=1, Sel_L=10, En_Out_H=En_Out_L=1. Go to MUL2.
- **MUL2**: same control word as MUL1. Go to DISP.
- **DISP**: Sel_out=01, Done=1. Go to IDLE.
- **SHOW_A**: Sel_out=10, Done=1. Go to IDLE.
- **SHOW_B**: Sel_out=11, Done=1. Go to IDLE.
- **ERR**: all control outputs 0, Err=1. Go to IDLE.
- **Wait counter** (width clog2(MAX_WAIT+1)):
  - Cleared in CALC_START and DIV_START.
  - Increments each cycle in CALC_ITER and DIV_ITER.
  - If it reaches MAX_WAIT−1 without the corresponding done flag, the next state is ERR.
  - A done flag in the same cycle as the timeout wins, so the FSM goes to the END state.
- `Done_Calc` is ignored outside the CALC states; `Done_DIV` is ignored outside the DIV states.

## Timing
- Reset: state IDLE, `f_q`=0, counter=0, all outputs 0 after the first `clk` edge with `reset`=1.
  - `reset` beats every other input, in any state, including mid-iteration.
- `Go` must be high at an edge while in IDLE to start. `Go` outside IDLE is ignored.
- `Go` held high through DISP restarts one cycle after returning to IDLE. IDLE always lasts at least 1 cycle.
- Latency, counted as edges from the Go-sampling edge to the first cycle with `Done` high:
  - SHOW_A / SHOW_B: 3.
  - mul: 6.
  - ALU (add/sub/and/xor) and div: 5 + n, where n = number of ITER cycles (0 if the done flag is high in the START state).
- Timeout: `Err` is high MAX_WAIT+3 cycles after the Go-sampling edge, followed by IDLE.

## Structure
- Shared package `calc_pkg` holds:
  - the state enum;
  - F opcode constants (`F_ADD` … `F_SHOW_B`);
  - Sel_L / Sel_out encodings;
  - the control-word field offsets, also used by the `DP` bench.
- Sub-module `calc_wait_timer` implements the clear/increment/expire counter. The FSM and output decode stay in `calc_cu`.

## Test plan
- F=101, Go pulse at edge 0, any operands → EN_X/EN_Y/EN_F high at cycle 1; MUL0..MUL2 at cycles 3–5; `Done`=1 and Sel_out=01 at cycle 6; IDLE at cycle 7.
- F=001, `Done_Calc` raised 3 cycles after CALC_START → Op_Calc=01 throughout; CALC_ITER lasts 3 cycles; `Done` at cycle 8.
- F=100, `Done_DIV` already high in DIV_START → no DIV_ITER; `Done` at cycle 5; En_Out_H=1 in DIV_END.
- F=000, `Done_Calc` never asserted, MAX_WAIT=16 → `Err`=1 for one cycle at cycle 19; `Done` never asserted; IDLE next.
- F=111 → Sel_out=11 with `Done` at cycle 3. Then `Go` held high → S1 re-entered at cycle 5.
- `reset` asserted during DIV_ITER → all outputs 0 and `Busy`=0 after that edge. A new `Go` then runs a clean sequence.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator control unit and its datapath.
//   state_t      - control unit FSM states
//   F_*          - function codes presented on F
//   SEL_L_*      - low-result source select encodings
//   SEL_OUT_*    - display mux select encodings
//   CW_*         - bit offsets of each field inside the 14-bit control word
//                  {EN_F, EN_X, EN_Y, Go_Calc, Op_Calc, Go_DIV, Sel_H, Sel_L,
//                   En_Out_H, En_Out_L, Sel_out}
package calc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_CALC_START,
        ST_CALC_ITER,
        ST_CALC_END,
        ST_DIV_START,
        ST_DIV_ITER,
        ST_DIV_END,
        ST_MUL0,
        ST_MUL1,
        ST_MUL2,
        ST_DISP,
        ST_SHOW_A,
        ST_SHOW_B,
        ST_ERR
    } state_t;

    localparam logic [2:0] F_ADD    = 3'b000;
    localparam logic [2:0] F_SUB    = 3'b001;
    localparam logic [2:0] F_AND    = 3'b010;
    localparam logic [2:0] F_XOR    = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_MUL    = 3'b101;
    localparam logic [2:0] F_SHOW_A = 3'b110;
    localparam logic [2:0] F_SHOW_B = 3'b111;

    localparam logic [1:0] SEL_L_NONE = 2'b00;
    localparam logic [1:0] SEL_L_ALU  = 2'b01;
    localparam logic [1:0] SEL_L_MUL  = 2'b10;
    localparam logic [1:0] SEL_L_DIV  = 2'b11;

    localparam logic [1:0] SEL_OUT_NONE = 2'b00;
    localparam logic [1:0] SEL_OUT_RES  = 2'b01;
    localparam logic [1:0] SEL_OUT_A    = 2'b10;
    localparam logic [1:0] SEL_OUT_B    = 2'b11;

    // Control word layout, LSB first.
    localparam int CW_W        = 14;
    localparam int CW_SEL_OUT  = 0;   // 2 bits
    localparam int CW_EN_OUT_L = 2;
    localparam int CW_EN_OUT_H = 3;
    localparam int CW_SEL_L    = 4;   // 2 bits
    localparam int CW_SEL_H    = 6;
    localparam int CW_GO_DIV   = 7;
    localparam int CW_OP_CALC  = 8;   // 2 bits
    localparam int CW_GO_CALC  = 10;
    localparam int CW_EN_Y     = 11;
    localparam int CW_EN_X     = 12;
    localparam int CW_EN_F     = 13;

endpackage

// File: rtl/calc_wait_timer.sv
// calc_wait_timer: iteration watchdog for the control unit.
//   clk, srst  - clock, synchronous active-high reset
//   clr        - zero the count (START states)
//   inc        - count one iteration cycle (ITER states)
//   expired    - high during the iteration cycle that completes MAX_WAIT-1
//                iterations; the FSM times out at the end of that cycle
module calc_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(MAX_WAIT + 1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            cnt_next = cnt_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // The count reads 0 in the first iteration cycle, so the cycle holding
    // MAX_WAIT-2 is the one in which MAX_WAIT-1 iterations have elapsed.
    assign expired = inc && (cnt_reg == W'(MAX_WAIT - 2));

endmodule

// File: rtl/calc_cu.sv
// calc_cu: Moore control unit sequencing the 4-bit calculator datapath.
//   clk, reset            - clock, synchronous active-high reset
//   Go, F                 - start request and function code (sampled in IDLE)
//   Done_Calc, Done_DIV   - completion flags from the ALU and divider
//   EN_F/EN_X/EN_Y        - function/operand register loads
//   Go_Calc, Op_Calc      - ALU run and operation (latched F[1:0])
//   Go_DIV                - divider run
//   Sel_H, Sel_L          - result source selects
//   En_Out_H, En_Out_L    - result register loads
//   Sel_out               - display mux select
//   Done, Err, Busy       - completion pulse, timeout pulse, not-idle
module calc_cu
    import calc_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Go,
    input  logic [2:0] F,
    input  logic       Done_Calc,
    input  logic       Done_DIV,
    output logic       EN_F,
    output logic       EN_X,
    output logic       EN_Y,
    output logic       Go_Calc,
    output logic [1:0] Op_Calc,
    output logic       Go_DIV,
    output logic       Sel_H,
    output logic [1:0] Sel_L,
    output logic       En_Out_H,
    output logic       En_Out_L,
    output logic [1:0] Sel_out,
    output logic       Done,
    output logic       Err,
    output logic       Busy
);
    state_t          state_reg;
    state_t          state_next;
    logic [2:0]      f_q;
    logic [CW_W-1:0] cw;
    logic            done_w;
    logic            err_w;
    logic            tmr_clr;
    logic            tmr_inc;
    logic            tmr_expired;

    assign tmr_clr = (state_reg == ST_CALC_START) || (state_reg == ST_DIV_START);
    assign tmr_inc = (state_reg == ST_CALC_ITER)  || (state_reg == ST_DIV_ITER);

    calc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .srst    (reset),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            f_q       <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && Go) begin
                f_q <= F;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cw         = '0;
        done_w     = 1'b0;
        err_w      = 1'b0;
        cw[CW_OP_CALC +: 2] = f_q[1:0];
        unique case (state_reg)
            ST_IDLE: begin
                if (Go) state_next = ST_S1;
            end
            ST_S1: begin
                cw[CW_EN_F] = 1'b1;
                cw[CW_EN_X] = 1'b1;
                cw[CW_EN_Y] = 1'b1;
                state_next  = ST_S2;
            end
            ST_S2: begin
                cw[CW_EN_F] = 1'b1;
                if (!f_q[2])                 state_next = ST_CALC_START;
                else if (f_q == F_DIV)       state_next = ST_DIV_START;
                else if (f_q == F_MUL)       state_next = ST_MUL0;
                else if (f_q == F_SHOW_A)    state_next = ST_SHOW_A;
                else                         state_next = ST_SHOW_B;
            end
            ST_CALC_START: begin
                cw[CW_GO_CALC] = 1'b1;
                state_next = Done_Calc ? ST_CALC_END : ST_CALC_ITER;
            end
            ST_CALC_ITER: begin
                cw[CW_GO_CALC]    = 1'b1;
                cw[CW_SEL_L +: 2] = SEL_L_ALU;
                cw[CW_EN_OUT_L]   = 1'b1;
                // A done flag arriving in the timeout cycle still completes.
                if (Done_Calc)        state_next = ST_CALC_END;
                else if (tmr_expired) state_next = ST_ERR;
            end
            ST_CALC_END: begin
                cw[CW_SEL_L +: 2] = SEL_L_ALU;
                cw[CW_EN_OUT_L]   = 1'b1;
                state_next        = ST_DISP;
            end
            ST_DIV_START: begin
                cw[CW_GO_DIV] = 1'b1;
                state_next = Done_DIV ? ST_DIV_END : ST_DIV_ITER;
            end
            ST_DIV_ITER: begin
                cw[CW_GO_DIV]     = 1'b1;
                cw[CW_SEL_L +: 2] = SEL_L_DIV;
                cw[CW_EN_OUT_H]   = 1'b1;
                cw[CW_EN_OUT_L]   = 1'b1;
                if (Done_DIV)         state_next = ST_DIV_END;
                else if (tmr_expired) state_next = ST_ERR;
            end
            ST_DIV_END: begin
                cw[CW_SEL_L +: 2] = SEL_L_DIV;
                cw[CW_EN_OUT_H]   = 1'b1;
                cw[CW_EN_OUT_L]   = 1'b1;
                state_next        = ST_DISP;
            end
            ST_MUL0: begin
                cw[CW_SEL_H]      = 1'b1;
                cw[CW_SEL_L +: 2] = SEL_L_MUL;
                state_next        = ST_MUL1;
            end
            ST_MUL1, ST_MUL2: begin
                cw[CW_SEL_H]      = 1'b1;
                cw[CW_SEL_L +: 2] = SEL_L_MUL;
                cw[CW_EN_OUT_H]   = 1'b1;
                cw[CW_EN_OUT_L]   = 1'b1;
                state_next = (state_reg == ST_MUL1) ? ST_MUL2 : ST_DISP;
            end
            ST_DISP: begin
                cw[CW_SEL_OUT +: 2] = SEL_OUT_RES;
                done_w     = 1'b1;
                state_next = ST_IDLE;
            end
            ST_SHOW_A: begin
                cw[CW_SEL_OUT +: 2] = SEL_OUT_A;
                done_w     = 1'b1;
                state_next = ST_IDLE;
            end
            ST_SHOW_B: begin
                cw[CW_SEL_OUT +: 2] = SEL_OUT_B;
                done_w     = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                err_w      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign EN_F     = cw[CW_EN_F];
    assign EN_X     = cw[CW_EN_X];
    assign EN_Y     = cw[CW_EN_Y];
    assign Go_Calc  = cw[CW_GO_CALC];
    assign Op_Calc  = cw[CW_OP_CALC +: 2];
    assign Go_DIV   = cw[CW_GO_DIV];
    assign Sel_H    = cw[CW_SEL_H];
    assign Sel_L    = cw[CW_SEL_L +: 2];
    assign En_Out_H = cw[CW_EN_OUT_H];
    assign En_Out_L = cw[CW_EN_OUT_L];
    assign Sel_out  = cw[CW_SEL_OUT +: 2];
    assign Done     = done_w;
    assign Err      = err_w;
    assign Busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_calc_cu.sv
// tb_calc_cu: randomized self-checking bench for calc_cu. Each operation is
// predicted cycle by cycle from a schedule model (cycles counted from the
// Go-sampling edge), with noise on ignored inputs.
module tb_calc_cu;
    localparam int MW = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       Go;
    logic [2:0] F;
    logic       Done_Calc;
    logic       Done_DIV;
    logic       EN_F, EN_X, EN_Y, Go_Calc, Go_DIV, Sel_H, En_Out_H, En_Out_L;
    logic [1:0] Op_Calc, Sel_L, Sel_out;
    logic       Done, Err, Busy;

    int total = 0;
    int bad   = 0;

    calc_cu #(.MAX_WAIT(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .Go        (Go),
        .F         (F),
        .Done_Calc (Done_Calc),
        .Done_DIV  (Done_DIV),
        .EN_F      (EN_F),
        .EN_X      (EN_X),
        .EN_Y      (EN_Y),
        .Go_Calc   (Go_Calc),
        .Op_Calc   (Op_Calc),
        .Go_DIV    (Go_DIV),
        .Sel_H     (Sel_H),
        .Sel_L     (Sel_L),
        .En_Out_H  (En_Out_H),
        .En_Out_L  (En_Out_L),
        .Sel_out   (Sel_out),
        .Done      (Done),
        .Err       (Err),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    // {EN_F,EN_X,EN_Y,Go_Calc,Go_DIV,Sel_H,Sel_L,En_Out_H,En_Out_L,Sel_out,Done,Err,Busy}
    function automatic logic [14:0] act_word();
        return {EN_F, EN_X, EN_Y, Go_Calc, Go_DIV, Sel_H, Sel_L,
                En_Out_H, En_Out_L, Sel_out, Done, Err, Busy};
    endfunction

    // Expected outputs in cycle c after the start edge, where the done flag of
    // the selected unit rises in cycle 3+n (n >= MW means it never arrives).
    function automatic logic [14:0] exp_word(input logic [2:0] f, input int n, input int c);
        logic ef = 0, ex = 0, ey = 0, gc = 0, gd = 0, sh = 0, eh = 0, el = 0;
        logic dn = 0, er = 0, bz = 0;
        logic [1:0] sl = 2'b00, so = 2'b00;
        bit is_div = (f == 3'b100);
        bit tmo    = (n >= MW);
        int k      = tmo ? MW - 1 : n;
        if (c == 1) begin
            ef = 1; ex = 1; ey = 1; bz = 1;
        end else if (c == 2) begin
            ef = 1; bz = 1;
        end else if (f[2:1] == 2'b11) begin
            if (c == 3) begin so = f[0] ? 2'b11 : 2'b10; dn = 1; bz = 1; end
        end else if (f == 3'b101) begin
            if (c >= 3 && c <= 5) begin sh = 1; sl = 2'b10; bz = 1; end
            if (c == 4 || c == 5) begin eh = 1; el = 1; end
            if (c == 6) begin so = 2'b01; dn = 1; bz = 1; end
        end else begin
            if (c == 3) begin
                gc = !is_div; gd = is_div; bz = 1;
            end else if (c >= 4 && c < 4 + k) begin
                gc = !is_div; gd = is_div; bz = 1;
                sl = is_div ? 2'b11 : 2'b01; el = 1; eh = is_div;
            end else if (c == 4 + k) begin
                bz = 1;
                if (tmo) er = 1;
                else begin sl = is_div ? 2'b11 : 2'b01; el = 1; eh = is_div; end
            end else if (c == 5 + k && !tmo) begin
                so = 2'b01; dn = 1; bz = 1;
            end
        end
        return {ef, ex, ey, gc, gd, sh, sl, eh, el, so, dn, er, bz};
    endfunction

    function automatic int last_cycle(input logic [2:0] f, input int n);
        if (f[2:1] == 2'b11) return 3;
        if (f == 3'b101)     return 6;
        if (n >= MW)         return MW + 3;
        return 5 + n;
    endfunction

    // Runs one operation from IDLE and checks every cycle through the
    // return to IDLE, plus the Done latency.
    task automatic run_op(input string name, input logic [2:0] f, input int n, input bit noise);
        int L = last_cycle(f, n);
        int exp_lat = (f[2] == 1'b0 || f == 3'b100) && n >= MW ? -1 : L;
        int lat = -1;
        bit is_alu = !f[2];
        bit is_div = (f == 3'b100);
        logic [14:0] a, e;
        F = f; Go = 1'b1; Done_Calc = 1'b0; Done_DIV = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= L + 1; c++) begin
            F  = 3'($urandom);
            Go = (noise && c <= L) ? 1'($urandom) : 1'b0;
            Done_Calc = is_alu ? (c >= 3 + n) : (noise ? 1'($urandom) : 1'b0);
            Done_DIV  = is_div ? (c >= 3 + n) : (noise ? 1'($urandom) : 1'b0);
            #1;
            a = act_word();
            e = exp_word(f, n, c);
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s f=%b n=%0d c=%0d word actual=%h expected=%h", name, f, n, c, a, e);
            end
            total++;
            if (Op_Calc !== f[1:0]) begin
                bad++;
                $display("FAIL %s c=%0d Op_Calc actual=%b expected=%b", name, c, Op_Calc, f[1:0]);
            end
            if (Done === 1'b1 && lat < 0) lat = c;
            @(posedge clk); #1;
        end
        Go = 1'b0; Done_Calc = 1'b0; Done_DIV = 1'b0;
        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("FAIL %s latency actual=%0d expected=%0d", name, lat, exp_lat);
        end
        $display("op %s f=%b n=%0d done_latency=%0d", name, f, n, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1; Go = 1'b1; F = 3'b011; Done_Calc = 1'b1; Done_DIV = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (act_word() !== 15'd0 || Op_Calc !== 2'b00) begin
            bad++;
            $display("FAIL reset word actual=%h/%b expected=0/00", act_word(), Op_Calc);
        end
        reset = 1'b0; Go = 1'b0; Done_Calc = 1'b0; Done_DIV = 1'b0;
        @(posedge clk); #1;
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle Busy actual=%b expected=0", Busy);
        end
        $display("test_reset checked");
    endtask

    task automatic test_directed();
        run_op("mul",        3'b101, 0,   0);
        run_op("sub_iter3",  3'b001, 3,   0);
        run_op("div_fast",   3'b100, 0,   0);
        run_op("timeout",    3'b000, 100, 0);
        run_op("done_wins",  3'b011, MW - 1, 0);
        run_op("just_late",  3'b010, MW, 0);
        run_op("div_tmo",    3'b100, 100, 0);
        run_op("show_a",     3'b110, 0,   0);
    endtask

    task automatic test_back_to_back();
        F = 3'b111; Go = 1'b1; Done_Calc = 1'b0; Done_DIV = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 5) Go = 1'b0;
            if (c == 3 || c == 7) begin
                total++;
                if (Done !== 1'b1 || Sel_out !== 2'b11) begin
                    bad++;
                    $display("FAIL b2b c=%0d Done/Sel_out actual=%b/%b expected=1/11", c, Done, Sel_out);
                end
            end
            if (c == 4) begin
                total++;
                if (Busy !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b idle c=4 Busy actual=%b expected=0", Busy);
                end
            end
            if (c == 5) begin
                total++;
                if (EN_X !== 1'b1 || Busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b restart c=5 EN_X/Busy actual=%b/%b expected=1/1", EN_X, Busy);
                end
            end
        end
        @(posedge clk); #1;
        $display("test_back_to_back checked");
    endtask

    task automatic test_reset_mid(input logic [2:0] f);
        F = f; Go = 1'b1; Done_Calc = 1'b0; Done_DIV = 1'b0;
        @(posedge clk); #1;
        Go = 1'b0;
        repeat (5) @(posedge clk);   // now in cycle 6, an iterate state
        #1;
        total++;
        if (Busy !== 1'b1 || En_Out_L !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid pre Busy/En_Out_L actual=%b/%b expected=1/1", Busy, En_Out_L);
        end
        reset = 1'b1; Go = 1'b1;
        @(posedge clk); #1;
        total++;
        if (act_word() !== 15'd0 || Op_Calc !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid f=%b word actual=%h/%b expected=0/00", f, act_word(), Op_Calc);
        end
        reset = 1'b0; Go = 1'b0;
        @(posedge clk); #1;
        run_op("after_reset", 3'b101, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [2:0] f = 3'($urandom);
            int n = $urandom_range(0, MW + 3);
            run_op("rand", f, n, 1);
        end
    endtask

    initial begin
        reset = 1'b1; Go = 1'b0; F = 3'b000; Done_Calc = 1'b0; Done_DIV = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid(3'b100);
        test_reset_mid(3'b011);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
